// File: rtl/reg_share_pkg.sv
// Shared types and default sizing for the clock-gated shared-register controller.
package reg_share_pkg;

   typedef enum logic [1:0] {
      GATED  = 2'd0,
      WAKE   = 2'd1,
      ACTIVE = 2'd2
   } state_t;

   localparam int DEF_N_REQ    = 4;
   localparam int DEF_WIDTH    = 8;
   localparam int DEF_IDLE_CYC = 4;

endpackage

// File: rtl/reg_share_ctrl_if.sv
// Requester/register-side bundle of the shared-register controller.
interface reg_share_ctrl_if
   import reg_share_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   parameter int WIDTH = DEF_WIDTH
) ();

   logic [N_REQ-1:0]       req;
   logic [N_REQ*WIDTH-1:0] data_in;
   logic [N_REQ-1:0]       grant;
   logic                   reg_en;
   logic [WIDTH-1:0]       reg_d;
   logic                   cg_en;
   logic                   busy;

   modport master (
      output req, data_in,
      input  grant, reg_en, reg_d, cg_en, busy
   );

   modport slave (
      input  req, data_in,
      output grant, reg_en, reg_d, cg_en, busy
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: the search starts at ptr and wraps.
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int PTR_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N_REQ-1:0] winner,
   output logic             valid
);

   logic found;

   always_comb begin
      // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
      winner = '0;
      found  = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         int idx;
         idx = (int'(ptr) + k) % N_REQ;
         if (!found && req[idx]) begin
            winner[idx] = 1'b1;
            found       = 1'b1;
         end
      end
   end

   assign valid = |req;

endmodule

// File: rtl/reg_share_ctrl.sv
// Round-robin write access to one shared enabled register, with idle clock gating.
module reg_share_ctrl
   import reg_share_pkg::*;
#(
   parameter int N_REQ    = DEF_N_REQ,
   parameter int WIDTH    = DEF_WIDTH,
   parameter int IDLE_CYC = DEF_IDLE_CYC
) (
   input logic            clk,
   input logic            rst_n,
   reg_share_ctrl_if.slave bus
);

   localparam int PTR_W = $clog2(N_REQ);
   localparam int CNT_W = $clog2(IDLE_CYC + 1);

   state_t           state;
   logic [PTR_W-1:0] ptr;
   logic [CNT_W-1:0] idle_cnt;
   logic [N_REQ-1:0] grant_q;
   logic             reg_en_q;
   logic [WIDTH-1:0] reg_d_q;
   logic             cg_en_q;

   logic [N_REQ-1:0] win_oh;
   logic             win_valid;
   logic [PTR_W-1:0] win_idx;
   logic [PTR_W-1:0] ptr_next;
   logic [WIDTH-1:0] win_data;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_arb (
      .req    (bus.req),
      .ptr    (ptr),
      .winner (win_oh),
      .valid  (win_valid)
   );

   always_comb begin
      win_idx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (win_oh[i]) win_idx = PTR_W'(i);
      end
   end

   assign ptr_next = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
   assign win_data = bus.data_in[win_idx*WIDTH +: WIDTH];

   // Grants are issued on the WAKE exit edge too, so they first appear in ACTIVE
   // after the ICG has had a full cycle of cg_en to open.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= GATED;
         ptr      <= '0;
         idle_cnt <= '0;
         grant_q  <= '0;
         reg_en_q <= 1'b0;
         reg_d_q  <= '0;
         cg_en_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         grant_q  <= '0;
         reg_en_q <= 1'b0;
         case (state)
            GATED: begin
               if (|bus.req) begin
                  state   <= WAKE;
                  cg_en_q <= 1'b1;
               end
            end
            WAKE: begin
               state    <= ACTIVE;
               idle_cnt <= '0;
               if (win_valid) begin
                  grant_q  <= win_oh;
                  reg_en_q <= 1'b1;
                  reg_d_q  <= win_data;
                  ptr      <= ptr_next;
               end
            end
            ACTIVE: begin
               if (win_valid) begin
                  grant_q  <= win_oh;
                  reg_en_q <= 1'b1;
                  reg_d_q  <= win_data;
                  ptr      <= ptr_next;
                  idle_cnt <= '0;
               end else if (idle_cnt >= CNT_W'(IDLE_CYC - 1)) begin
                  state    <= GATED;
                  cg_en_q  <= 1'b0;
                  idle_cnt <= CNT_W'(IDLE_CYC);
               end else begin
                  idle_cnt <= idle_cnt + CNT_W'(1);
               end
            end
            default: begin
               state   <= GATED;
               cg_en_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.grant  = grant_q;
   assign bus.reg_en = reg_en_q;
   assign bus.reg_d  = reg_d_q;
   assign bus.cg_en  = cg_en_q;
   assign bus.busy   = cg_en_q;

endmodule
